// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 host transmitter: FSM state encoding, frame
// geometry and the parity helper.
package ps2_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_INHIBIT   = 4'd1;
  localparam logic [3:0] ST_REQ       = 4'd2;
  localparam logic [3:0] ST_DATA      = 4'd3;
  localparam logic [3:0] ST_STOP      = 4'd4;
  localparam logic [3:0] ST_ACK       = 4'd5;
  localparam logic [3:0] ST_WAIT_IDLE = 4'd6;
  localparam logic [3:0] ST_DONE      = 4'd7;
  localparam logic [3:0] ST_ERR       = 4'd8;

  localparam int unsigned DATA_BITS = 8;
  // Device falling edge on which the host samples the ACK bit.
  localparam int unsigned ACK_EDGE  = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request/status handshake between the system and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] send_data;
  logic       send_req;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output send_data,
    output send_req,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  send_data,
    input  send_req,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a debounce that moves its output only after
// FILTER_LEN consecutive samples agree on the new level.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level
);

  localparam int unsigned   CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte as an 11-bit frame on
// open-drain CLK/DAT, then reports done (ACK seen) or error (timeout / no ACK).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned PACKET_TIMEOUT = 100000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam int unsigned TMR_MAX =
      (INHIBIT_CYCLES > START_TIMEOUT)
        ? ((INHIBIT_CYCLES > PACKET_TIMEOUT) ? INHIBIT_CYCLES : PACKET_TIMEOUT)
        : ((START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT);
  localparam int unsigned   TW         = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] PKT_LAST   = TW'(PACKET_TIMEOUT - 1);

  logic          w_clk_filt;
  logic          w_dat_filt;
  logic          r_clk_prev;
  logic          r_fall;

  logic [3:0]    r_state;
  logic [3:0]    w_state_nxt;
  logic [7:0]    r_data;
  logic          r_dat_oe;
  logic          w_dat_oe_nxt;
  logic [3:0]    r_idx;
  logic [3:0]    w_idx_nxt;
  logic [TW-1:0] r_tmr;
  logic          w_tmr_clr;
  logic          w_accept;
  logic          w_pkt_expired;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filt (
    .i_clk  (CLOCK_50),
    .i_rst_n(RESET_N),
    .i_pin  (ps2_clk_in),
    .o_level(w_clk_filt)
  );

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_dat_filt (
    .i_clk  (CLOCK_50),
    .i_rst_n(RESET_N),
    .i_pin  (ps2_dat_in),
    .o_level(w_dat_filt)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_clk_prev <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_prev <= w_clk_filt;
      r_fall     <= r_clk_prev & ~w_clk_filt;
    end
  end

  // The packet timer spans DATA..WAIT_IDLE, so it is not cleared between those states.
  function automatic logic is_pkt(input logic [3:0] s);
    return (s == ST_DATA) || (s == ST_STOP) || (s == ST_ACK) || (s == ST_WAIT_IDLE);
  endfunction

  assign w_pkt_expired = (r_tmr == PKT_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_dat_oe_nxt = r_dat_oe;
    w_idx_nxt    = r_idx;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.send_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_tmr == INH_LAST) begin
          w_state_nxt  = ST_REQ;
          w_dat_oe_nxt = 1'b1;
          w_idx_nxt    = '0;
        end
      end
      ST_REQ: begin
        if (r_fall) begin
          w_dat_oe_nxt = ~r_data[0];
          w_idx_nxt    = 4'd1;
          w_state_nxt  = ST_DATA;
        end else if (r_tmr == START_LAST) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_DATA: begin
        if (w_pkt_expired) begin
          w_state_nxt = ST_ERR;
        end else if (r_fall) begin
          w_idx_nxt = r_idx + 4'd1;
          if (r_idx == 4'(DATA_BITS)) begin
            w_dat_oe_nxt = ~odd_parity(r_data);
            w_state_nxt  = ST_STOP;
          end else begin
            w_dat_oe_nxt = ~r_data[r_idx[2:0]];
          end
        end
      end
      ST_STOP: begin
        if (w_pkt_expired) begin
          w_state_nxt = ST_ERR;
        end else if (r_fall) begin
          w_idx_nxt    = r_idx + 4'd1;
          w_dat_oe_nxt = 1'b0;
          w_state_nxt  = ST_ACK;
        end
      end
      ST_ACK: begin
        if (w_pkt_expired) begin
          w_state_nxt = ST_ERR;
        end else if (r_fall && (r_idx == 4'(ACK_EDGE - 1))) begin
          w_idx_nxt   = r_idx + 4'd1;
          w_state_nxt = w_dat_filt ? ST_ERR : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_pkt_expired) begin
          w_state_nxt = ST_ERR;
        end else if (w_clk_filt && w_dat_filt) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERR:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE) || (w_state_nxt == ST_ERR)) begin
      w_dat_oe_nxt = 1'b0;
    end
    w_tmr_clr = (w_state_nxt != r_state) && !(is_pkt(r_state) && is_pkt(w_state_nxt));
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_dat_oe <= 1'b0;
      r_idx    <= '0;
      r_tmr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dat_oe <= w_dat_oe_nxt;
      r_idx    <= w_idx_nxt;
      if (w_accept) begin
        r_data <= bus.send_data;
      end
      if ((r_state == ST_IDLE) || w_tmr_clr) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + TW'(1);
      end
    end
  end

  assign ps2_clk_oe = (r_state == ST_INHIBIT);
  assign ps2_dat_oe = r_dat_oe;
  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.error  = (r_state == ST_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and a
// byte-level model predicts the captured bits and the done/error outcome.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int STO = 2000;
  localparam int PTO = 5000;

  typedef struct {
    logic [7:0] data;
    int         edges;
    bit         ack;
    bit         exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic dev_clk_rel;
  logic dev_dat_rel;
  logic clk_oe;
  logic dat_oe;
  logic clk_line;
  logic dat_line;

  ps2_host_tx_if bus ();

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int d_cnt    = 0;
  int e_cnt    = 0;
  int both_cnt = 0;
  int oe_run   = 0;
  int last_run = 0;
  int req_cyc  = 0;
  int err_cyc  = 0;
  int first_fall_cyc = 0;
  logic armed = 1'b0;
  logic prev_dat_oe = 1'b0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device drivers.
  assign clk_line = ~clk_oe & dev_clk_rel;
  assign dat_line = ~dat_oe & dev_dat_rel;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .PACKET_TIMEOUT(PTO),
    .FILTER_LEN    (2)
  ) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .bus       (bus),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(clk_oe),
    .ps2_dat_oe(dat_oe)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) d_cnt <= d_cnt + 1;
    if (bus.error) begin
      e_cnt   <= e_cnt + 1;
      err_cyc <= cyc;
    end
    if (bus.done && bus.error) both_cnt <= both_cnt + 1;
    if (clk_oe) begin
      oe_run <= oe_run + 1;
      armed  <= 1'b1;
    end else if (oe_run != 0) begin
      last_run <= oe_run;
      oe_run   <= 0;
    end
    if (armed && dat_oe && !prev_dat_oe) begin
      req_cyc <= cyc;
      armed   <= 1'b0;
    end
    prev_dat_oe <= dat_oe;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Frame as the device should see it on rising edges 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] model_bits(input logic [7:0] d);
    logic [9:0] b;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      b[i] = d[i];
      if (d[i]) ones++;
    end
    b[8] = ((ones % 2) == 0);
    b[9] = 1'b1;
    return b;
  endfunction

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    while (bus.busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    bus.send_data = d;
    bus.send_req  = 1'b1;
    @(negedge clk);
    bus.send_req  = 1'b0;
  endtask

  // Device: waits for the host request, then produces 'edges' clock pulses of period 2*half.
  task automatic dev_frame(input int edges, input bit ack, input int half,
                           output logic [9:0] bits);
    int t;
    bits = '0;
    t = 0;
    while (!(dat_line == 1'b0 && clk_oe == 1'b0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("dev_req_seen", int'(t < 5000), 1);
    repeat (half) @(negedge clk);
    for (int k = 1; k <= edges; k++) begin
      if (k == 1) first_fall_cyc = cyc;
      dev_clk_rel = 1'b0;
      repeat (half) @(negedge clk);
      dev_clk_rel = 1'b1;
      if (k <= 10) bits[k-1] = dat_line;
      if (k == 10 && ack) begin
        repeat (half / 2) @(negedge clk);
        dev_dat_rel = 1'b0;
        repeat (half - half / 2) @(negedge clk);
      end else if (k == 11) begin
        dev_dat_rel = 1'b1;
        repeat (half) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input int edges,
                           input bit ack, input int half, input bit exp_done);
    logic [9:0] bits;
    int bd;
    int be;
    int t;
    bd = d_cnt;
    be = e_cnt;
    send(d);
    check({tag, "_busy_hi"}, int'(bus.busy), 1);
    dev_frame(edges, ack, half, bits);
    t = 0;
    while (d_cnt == bd && e_cnt == be && t < 8000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_done"}, d_cnt - bd, exp_done ? 1 : 0);
    check({tag, "_err"}, e_cnt - be, exp_done ? 0 : 1);
    check({tag, "_busy_lo"}, int'(bus.busy), 0);
    check({tag, "_oe"}, int'({clk_oe, dat_oe}), 0);
    if (edges >= 10) check({tag, "_bits"}, int'(bits), int'(model_bits(d)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [4];
    logic [9:0] hbits;
    logic [7:0] first;
    logic [7:0] rd;
    int bd;
    int be;
    int half;
    bit ack;
    bit got;

    rst_n = 1'b0;
    dev_clk_rel = 1'b1;
    dev_dat_rel = 1'b1;
    bus.send_req  = 1'b0;
    bus.send_data = 8'h00;
    #3;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_error", int'(bus.error), 0);
    check("rst_clk_oe", int'(clk_oe), 0);
    check("rst_dat_oe", int'(dat_oe), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    vecs[0] = '{8'hED, 11, 1'b1, 1'b1};
    vecs[1] = '{8'h01, 11, 1'b1, 1'b1};
    vecs[2] = '{8'hFF, 11, 1'b1, 1'b1};
    vecs[3] = '{8'hF4, 11, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].edges, vecs[i].ack, 100,
                vecs[i].exp_done);
    end

    for (int i = 0; i < 6; i++) begin
      rd   = 8'($urandom_range(0, 255));
      half = int'($urandom_range(40, 110));
      ack  = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", i), rd, 11, ack, half, ack);
    end

    // Device never clocks: start timeout measured from REQ entry.
    run_frame("start_tmo", 8'h55, 0, 1'b0, 100, 1'b0);
    check("inhibit_len", last_run, INH);
    check("start_tmo_at", err_cyc - req_cyc, STO);

    // Device stops after 4 edges: packet timeout from the first falling edge.
    run_frame("pkt_tmo", 8'hF3, 4, 1'b0, 100, 1'b0);
    check_rng("pkt_tmo_at", err_cyc - first_fall_cyc, PTO, PTO + 25);

    // Request held high throughout: exactly one frame, carrying the first byte.
    bd = d_cnt;
    be = e_cnt;
    got = 1'b0;
    first = 8'h00;
    fork
      begin
        for (int n = 0; n < 6000; n++) begin
          @(negedge clk);
          if (bus.done) begin
            got = 1'b1;
            break;
          end
          bus.send_data = 8'($urandom_range(0, 255));
          if (n == 0) first = bus.send_data;
          bus.send_req = 1'b1;
        end
        bus.send_req = 1'b0;
      end
      dev_frame(11, 1'b1, 100, hbits);
    join
    check("hold_done_seen", int'(got), 1);
    @(negedge clk);
    check("hold_idle_busy", int'(bus.busy), 0);
    check("hold_idle_clk_oe", int'(clk_oe), 0);
    check("hold_done_cnt", d_cnt - bd, 1);
    check("hold_err_cnt", e_cnt - be, 0);
    check("hold_bits", int'(hbits), int'(model_bits(first)));

    // Reset in the middle of DATA releases the lines without waiting for a clock edge.
    send(8'h00);
    dev_frame(4, 1'b1, 100, hbits);
    check("pre_rst_dat_oe", int'(dat_oe), 1);
    check("pre_rst_busy", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_clk_oe", int'(clk_oe), 0);
    check("mid_rst_dat_oe", int'(dat_oe), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_frame("post_rst", 8'hED, 11, 1'b1, 100, 1'b1);

    check("done_error_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter, the send side of the keyboard link. The existing PS/2 receive path only listens; this block lets the system send command bytes to the keyboard (e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic). It takes one byte over a request/busy handshake and sends it as an 11-bit host-to-device frame on open-drain PS2_CLK/PS2_DAT. It reports done or error, and `busy` tells the receiver to ignore the bus during the transfer.

Parameters:
INHIBIT_CYCLES, 6000, cycles the host holds CLK low before the request (120 us at 50 MHz)
START_TIMEOUT, 750000, cycles allowed from request to the first device falling edge (15 ms)
PACKET_TIMEOUT, 100000, cycles allowed from the first falling edge to the ACK (2 ms)
FILTER_LEN, 8, consecutive equal samples needed to accept a level change on CLK/DAT

Ports:
CLOCK_50  in  1  system clock, 50 MHz
RESET_N  in  1  asynchronous active-low reset
send_data  in  8  byte to transmit
send_req  in  1  1-cycle request; sampled only when busy=0
busy  out  1  high from the cycle after an accepted request until done/error
done  out  1  1-cycle pulse: frame sent and ACK received
error  out  1  1-cycle pulse: timeout or missing ACK
ps2_clk_in  in  1  raw PS2_CLK pin level
ps2_dat_in  in  1  raw PS2_DAT pin level
ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (top level: PS2_CLK = oe ? 0 : z)
ps2_dat_oe  out  1  1 = drive PS2_DAT low; 0 = release

Behaviour:
- Reset (async, RESET_N=0):
  - busy=0, done=0, error=0, ps2_clk_oe=0, ps2_dat_oe=0, state=IDLE.
  - Filters preset to 1, counters cleared.
  - Reset mid-frame releases both lines immediately.
- Input conditioning:
  - Each pin passes a 2-FF synchronizer, then a filter that updates its output only after FILTER_LEN identical samples.
  - fall = filtered CLK 1 -> 0, registered as a 1-cycle strobe.
- Send byte is latched at acceptance. Frame bits, in order:
  - 8 data bits, LSB first;
  - odd parity bit p = ~^send_data;
  - stop = release (1).
- States:
  - IDLE: outputs released. send_req=1 latches send_data and moves to INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then move to REQ.
  - REQ: clk_oe=0, dat_oe=1 (start bit), bit index=0, START timer running.
    - fall -> apply bit0 (dat_oe = ~bit) in the same cycle as the strobe, go to DATA, start PACKET timer.
    - START timer expiry -> ERR.
  - DATA: on each fall, present the next bit. After bit7 has been presented, the next fall presents parity and moves to STOP.
  - STOP: the next fall (falling edge 10) sets dat_oe=0 and moves to ACK.
  - ACK: at falling edge 11, sample filtered DAT.
    - DAT=0 -> WAIT_IDLE.
    - DAT=1 -> ERR.
  - WAIT_IDLE: wait until filtered CLK=1 and DAT=1, then DONE.
  - DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
  - ERR: release both lines, error=1 for one cycle, go to IDLE.
- Timeouts:
  - PACKET timer expiry in any of DATA/STOP/ACK/WAIT_IDLE -> ERR.
  - Timers are cleared on state entry. Counters are wide enough for the largest parameter.
- Handshake rules:
  - send_req while busy=1 is ignored (not queued).
  - done and error are never asserted together.
  - A new send_req in the same cycle as done/error is ignored; it is accepted once IDLE is reached.
- A device-initiated clock during INHIBIT is overridden by the host hold and is not counted.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, DATA, STOP, ACK, WAIT_IDLE, DONE, ERR);
  - the frame constants (DATA_BITS=8, ACK_EDGE=11);
  - the odd-parity function.
- Sub-module ps2_line_filter (synchronizer + FILTER_LEN debounce, parameter FILTER_LEN). It is instantiated twice, once for CLK and once for DAT.

Test Plan (bench uses a PS/2 device model; INHIBIT_CYCLES=20, START_TIMEOUT=2000, PACKET_TIMEOUT=5000, FILTER_LEN=2):
- send 0xED, device clocks at period 200 -> bits sampled on rising edges 1..10 are 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACKs low. One done pulse, busy drops, error never asserted.
- send 0x01 -> parity bit sampled = 0, done pulse. Then send 0xFF -> parity 1, done pulse. Confirms back-to-back sends.
- send 0x55, device never clocks -> clk_oe held exactly 20 cycles. Error pulse START_TIMEOUT cycles after REQ entry, both oe=0, busy=0.
- send 0xF4, device leaves DAT high at the ACK edge -> error pulse, no done.
- send 0xF3, device stops clocking after 4 edges -> error at PACKET_TIMEOUT. Lines released.
- Assert send_req every cycle while busy -> exactly one frame sent. Then drop RESET_N mid-DATA -> clk_oe=dat_oe=busy=0 asynchronously; next send after reset completes normally.
